sqrt_share_ctrl: RTL

Round-robin controller that shares one `fixed_sqrt` engine (Q8.8 in, Q8.8 out, `start`/`done` protocol) among `NREQ` requesters. It accepts one request at a time, sequences the engine's start pulse and done wait, and returns the result tagged with the requester ID on a single response channel. It sits between the client blocks and the engine instance, and owns the engine's `start` and `x_in` inputs exclusively.

---
 rtl/sqrt_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/sqrt_share_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sqrt_pkg.sv
// Shared types and constants for the square-root sharing controller.
package sqrt_pkg;

    localparam int SQRT_W    = 16;
    localparam int SQRT_FRAC = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        ARM   = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } sqrt_share_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first active request at or after ptr wins.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    int unsigned cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = (int'(ptr) + i) % NREQ;
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/sqrt_share_ctrl.sv
// Shares one fixed_sqrt engine among NREQ requesters, one operation at a time.
// Optional watchdog on the engine's done: define SQRT_SHARE_TIMEOUT_EN.
module sqrt_share_ctrl
    import sqrt_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int TIMEOUT = 64,
    localparam int ID_W    = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*SQRT_W-1:0]   req_x,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [SQRT_W-1:0]        rsp_data,
    output logic                     rsp_err,
    output logic                     sqrt_start,
    output logic [SQRT_W-1:0]        sqrt_x,
    input  logic [SQRT_W-1:0]        sqrt_result,
    input  logic                     sqrt_done,
    output logic                     busy
);

    // Handshakes: a request transfers when req_valid[i] && req_ready[i] at a rising
    // edge; a response transfers when rsp_valid && rsp_ready. Once valid is up, the
    // sender holds valid and payload stable until the transfer happens.

    sqrt_share_state_t state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [SQRT_W-1:0] x_q, x_d;
    logic [SQRT_W-1:0] data_q, data_d;

    logic [NREQ-1:0]   arb_gnt;
    logic [ID_W-1:0]   arb_idx;
    logic              arb_any;

`ifdef SQRT_SHARE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timed_out;

    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            x_q     <= '0;
            data_q  <= '0;
`ifdef SQRT_SHARE_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            x_q     <= x_d;
            data_q  <= data_d;
`ifdef SQRT_SHARE_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        x_d     = x_q;
        data_d  = data_q;
`ifdef SQRT_SHARE_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d = ISSUE;
                    id_d    = arb_idx;
                    x_d     = req_x[int'(arb_idx)*SQRT_W +: SQRT_W];
                    ptr_d   = (arb_idx == ID_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
`ifdef SQRT_SHARE_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ISSUE: state_d = ARM;
            // done may still be high from the previous operation, so it is not looked at here
            ARM: begin
                state_d = WAIT;
`ifdef SQRT_SHARE_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (sqrt_done) begin
                    state_d = RESP;
                    data_d  = sqrt_result;
                end
`ifdef SQRT_SHARE_TIMEOUT_EN
                else if (timed_out) begin
                    state_d = RESP;
                    data_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        sqrt_start = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state_q)
            IDLE: begin
                req_ready = arb_gnt;
                busy      = 1'b0;
            end
            ISSUE:   sqrt_start = 1'b1;
            RESP:    rsp_valid  = 1'b1;
            default: ;
        endcase
    end

    assign rsp_id   = id_q;
    assign rsp_data = data_q;
    assign sqrt_x   = x_q;
`ifdef SQRT_SHARE_TIMEOUT_EN
    assign rsp_err  = err_q;
`else
    assign rsp_err  = 1'b0;
`endif

endmodule
